dm_port_arbiter: RTL and testbench
==================================

# dm_port_arbiter

Shares the single data-memory port between the core's data-access path and one external host requester (DMA/debug loader). The core path covers the PS chip-select and write strobe, the DAG address and the BC write data. The block sits between the core and the `memory` block's DM side. It grants one access per cycle, routes synchronous read data back to its owner, and can stall the core so the host is not starved.

## Interface
Parameters:
- DMA_SIZE, 16, DM address width
- DMD_SIZE, 16, DM data width
- STARVE_LIMIT, 4, consecutive denied host cycles before forced host grant (1..15)

Ports:
- clk  in  1  single core clock; everything is sampled on its rising edge
- reset  in  1  synchronous, active-high
- core_req  in  1  core DM access request; single-cycle, level-sampled each cycle
- core_wrb  in  1  0 = write, 1 = read
- core_add  in  DMA_SIZE  core address
- core_wdt  in  DMD_SIZE  core write data
- core_rdt  out  DMD_SIZE  core read data
- core_stall  out  1  high = core access not taken this cycle; the core must hold its request
- host_req  in  1  host request; held until granted
- host_wrb  in  1  0 = write, 1 = read
- host_add  in  DMA_SIZE  host address
- host_wdt  in  DMD_SIZE  host write data
- host_gnt  out  1  one-cycle pulse: host access issued this cycle
- host_rdt  out  DMD_SIZE  host read data
- host_rvalid  out  1  one-cycle pulse: host_rdt is valid
- mem_cslt  out  1  DM chip select, active high
- mem_wrb  out  1  DM write strobe, active low
- mem_add  out  DMA_SIZE  DM address
- mem_wdt  out  DMD_SIZE  DM write data
- mem_rdt  in  DMD_SIZE  DM read data, valid the cycle after a read is issued

## Operation
- Grant selection is combinational within the cycle:
  - Force condition F = starve_cnt == STARVE_LIMIT and host_req.
  - If F: host is granted.
  - Else if core_req: core is granted.
  - Else if host_req: host is granted.
  - Else: idle.
- mem_* carry the granted requester's wrb/add/wdt, with mem_cslt = 1.
- When idle: mem_cslt = 0, mem_wrb = 1, mem_add and mem_wdt = 0.
- core_stall = core_req and not core granted.
- host_gnt = host granted.
- Read-return tracker, a 2-bit register rd_own with states:
  - NONE → CORE on a core read grant.
  - NONE → HOST on a host read grant.
  - Any state → NONE when the cycle's grant is a write or idle.
  - Any state → CORE/HOST on back-to-back read grants; pipelined, no bubble.
- When rd_own == CORE: core_rdt_q <= mem_rdt. core_rdt = core_rdt_q, which holds its last value otherwise.
- When rd_own == HOST: host_rdt_q <= mem_rdt, and host_rvalid pulses. host_rdt holds its value otherwise.
- starve_cnt (4-bit), updated every cycle:
  - Cleared on any host grant, or when host_req = 0.
  - Incremented when host_req is high and the host is denied.
  - Saturates at STARVE_LIMIT.
- A write and a read may be granted to different requesters on consecutive cycles; rd_own handles this without conflict.

## Timing
- Reset values:
  - core_rdt, host_rdt = 0.
  - host_gnt, host_rvalid, core_stall, mem_cslt = 0.
  - mem_wrb = 1.
  - mem_add, mem_wdt = 0.
  - rd_own = NONE, starve_cnt = 0.
- Reset mid-operation: any pending read return is dropped, so no host_rvalid follows reset.
- Core read granted in cycle N: mem_rdt is sampled at the end of N+1, and core_rdt shows it from N+2.
- Host read granted in cycle N: host_rvalid is high in N+1, and host_rdt is valid in N+1. host_rdt is driven combinationally from mem_rdt during the valid cycle, then held.
- Writes complete in the grant cycle; there is no return.
- Forced grant: with core_req continuously high, the host is granted in its (STARVE_LIMIT+1)-th requesting cycle. core_stall = 1 in exactly that cycle.
- Simultaneous host_req and core_req with counter below the limit: core wins, and starve_cnt increments.

## Configuration
- DM_ARB_STARVE_GUARD_EN:
  - Defined: starvation counter and forced host grant operate as described above.
  - Undefined: the counter is removed and priority is strict core-first. core_stall is tied to 0, and the host is served only in core-idle cycles.

## Test plan
- Reset with both requests active: all outputs hold reset values; after release, the core is granted first and mem_wrb = 1 while idle.
- Core read at 0x0010 with memory word 0xBEEF: mem_cslt high in N; core_rdt = 0xBEEF from N+2; host_rvalid stays 0.
- Host write 0x0020 ← 0x1234 with core idle: host_gnt pulses the same cycle; mem_wrb = 0, mem_add = 0x0020, mem_wdt = 0x1234.
- Core_req held high plus host read of 0x0030 (data 0x5A5A), STARVE_LIMIT = 4: host granted in the 5th cycle with core_stall = 1 only then; host_rvalid and host_rdt = 0x5A5A next cycle; starve_cnt back to 0.
- Back-to-back core read 0x0001 (0xAAAA), then host read 0x0002 (0x5555): host_rvalid carries 0x5555; core_rdt shows 0xAAAA, unchanged by the host return.
- Build without DM_ARB_STARVE_GUARD_EN, same stimulus as scenario 4: core_stall never asserts, and the host is granted only after core_req drops.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - single DM port shared between the core data path and one host requester
// Optional feature macro: DM_ARB_STARVE_GUARD_EN (starvation counter with forced host grant).
module dm_port_arbiter #(
  parameter int DMA_SIZE     = 16,
  parameter int DMD_SIZE     = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                core_req,
  input  logic                core_wrb,
  input  logic [DMA_SIZE-1:0] core_add,
  input  logic [DMD_SIZE-1:0] core_wdt,
  output logic [DMD_SIZE-1:0] core_rdt,
  output logic                core_stall,
  input  logic                host_req,
  input  logic                host_wrb,
  input  logic [DMA_SIZE-1:0] host_add,
  input  logic [DMD_SIZE-1:0] host_wdt,
  output logic                host_gnt,
  output logic [DMD_SIZE-1:0] host_rdt,
  output logic                host_rvalid,
  output logic                mem_cslt,
  output logic                mem_wrb,
  output logic [DMA_SIZE-1:0] mem_add,
  output logic [DMD_SIZE-1:0] mem_wdt,
  input  logic [DMD_SIZE-1:0] mem_rdt
);

  // An out-of-range limit cannot be represented by the 4-bit counter; refuse to elaborate.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    dm_port_arbiter_illegal_starve_limit u_bad ();
  end

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } own_t;

  own_t                rd_own;
  own_t                rd_own_nxt;
  logic                gnt_core;
  logic                gnt_host;
  logic                force_host;
  logic [DMD_SIZE-1:0] core_rdt_q;
  logic [DMD_SIZE-1:0] host_rdt_q;

`ifdef DM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  // Count consecutive denied host cycles, saturating at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (gnt_host || !host_req) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign force_host = (starve_cnt == LIMIT) && host_req;
  assign core_stall = core_req && !gnt_core && !reset;
`else
  // Strict core-first: the core is never refused, the host only fills idle cycles.
  assign force_host = 1'b0;
  assign core_stall = 1'b0;
`endif

  // Pick at most one requester per cycle; nothing is granted while in reset.
  always_comb begin
    gnt_core = 1'b0;
    gnt_host = 1'b0;
    if (!reset) begin
      if (force_host) begin
        gnt_host = 1'b1;
      end else if (core_req) begin
        gnt_core = 1'b1;
      end else if (host_req) begin
        gnt_host = 1'b1;
      end
    end
  end

  // Steer the granted requester onto the DM port; park it quietly when idle.
  always_comb begin
    mem_cslt = 1'b0;
    mem_wrb  = 1'b1;
    mem_add  = '0;
    mem_wdt  = '0;
    if (gnt_core) begin
      mem_cslt = 1'b1;
      mem_wrb  = core_wrb;
      mem_add  = core_add;
      mem_wdt  = core_wdt;
    end else if (gnt_host) begin
      mem_cslt = 1'b1;
      mem_wrb  = host_wrb;
      mem_add  = host_add;
      mem_wdt  = host_wdt;
    end
  end

  assign host_gnt = gnt_host;

  // Read-return owner register: remembers who issued the read now returning data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_own <= OWN_NONE;
    end else begin
      rd_own <= rd_own_nxt;
    end
  end

  // Next owner follows this cycle's grant; writes and idle cycles leave nothing in flight.
  always_comb begin
    rd_own_nxt = OWN_NONE;
    if (gnt_core && core_wrb) begin
      rd_own_nxt = OWN_CORE;
    end else if (gnt_host && host_wrb) begin
      rd_own_nxt = OWN_HOST;
    end
  end

  // Capture returning read data for its owner; each side holds its last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_rdt_q <= '0;
      host_rdt_q <= '0;
    end else begin
      if (rd_own == OWN_CORE) begin
        core_rdt_q <= mem_rdt;
      end
      if (rd_own == OWN_HOST) begin
        host_rdt_q <= mem_rdt;
      end
    end
  end

  assign core_rdt    = core_rdt_q;
  assign host_rvalid = (rd_own == OWN_HOST) && !reset;
  // The host sees its data in the return cycle itself, then the held copy.
  assign host_rdt    = host_rvalid ? mem_rdt : host_rdt_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - scoreboard bench for dm_port_arbiter with a behavioural arbitration model
module tb_dm_port_arbiter;

`ifdef DM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_req = 1'b0, core_wrb = 1'b1;
  logic [15:0] core_add = '0, core_wdt = '0;
  logic [15:0] core_rdt;
  logic        core_stall;
  logic        host_req = 1'b0, host_wrb = 1'b1;
  logic [15:0] host_add = '0, host_wdt = '0;
  logic        host_gnt;
  logic [15:0] host_rdt;
  logic        host_rvalid;
  logic        mem_cslt, mem_wrb;
  logic [15:0] mem_add, mem_wdt;
  logic [15:0] mem_rdt;

  dm_port_arbiter #(.DMA_SIZE(16), .DMD_SIZE(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_wrb(core_wrb), .core_add(core_add), .core_wdt(core_wdt),
    .core_rdt(core_rdt), .core_stall(core_stall),
    .host_req(host_req), .host_wrb(host_wrb), .host_add(host_add), .host_wdt(host_wdt),
    .host_gnt(host_gnt), .host_rdt(host_rdt), .host_rvalid(host_rvalid),
    .mem_cslt(mem_cslt), .mem_wrb(mem_wrb), .mem_add(mem_add), .mem_wdt(mem_wdt),
    .mem_rdt(mem_rdt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 16'h0101 ^ 16'h3C5A);
  endfunction

  // Synchronous-read data memory attached to the DM port.
  logic [15:0] phys_mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) phys_mem[i] = init_val(i);
    mem_rdt = '0;
    forever begin
      @(posedge clk);
      if (mem_cslt) begin
        if (!mem_wrb) phys_mem[mem_add[7:0]] = mem_wdt;
        else mem_rdt <= phys_mem[mem_add[7:0]];
      end
    end
  end

  typedef struct {
    int          due;
    logic [15:0] val;
  } ret_t;

  ret_t        cq[$];
  ret_t        hq[$];
  logic [15:0] ref_mem [0:255];
  logic [15:0] exp_core = '0;
  logic [15:0] exp_host = '0;
  int          scnt = 0;
  bit          core_hold = 1'b0;
  bit          host_clear = 1'b0;
  bit          seen_gnt, seen_stall;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model of one arbitration cycle, evaluated from the driven request values.
  task automatic model_cycle();
    bit          hr, cr, fh, gh, gc;
    logic        e_wrb;
    logic [15:0] e_add, e_wdt;
    hr = host_req;
    cr = core_req;
    fh = GUARD && (scnt == LIMIT) && hr;
    gh = fh || (!cr && hr);
    gc = !fh && cr;
    e_wrb = gc ? core_wrb : (gh ? host_wrb : 1'b1);
    e_add = gc ? core_add : (gh ? host_add : 16'h0);
    e_wdt = gc ? core_wdt : (gh ? host_wdt : 16'h0);
    chk("mem_cslt", mem_cslt, gc | gh);
    chk("mem_wrb", mem_wrb, e_wrb);
    chk("mem_add", mem_add, e_add);
    chk("mem_wdt", mem_wdt, e_wdt);
    chk("host_gnt", host_gnt, gh);
    chk("core_stall", core_stall, cr && !gc);
    if (gc || gh) begin
      if (e_wrb) begin
        if (gc) cq.push_back('{cyc + 2, ref_mem[e_add[7:0]]});
        else    hq.push_back('{cyc + 1, ref_mem[e_add[7:0]]});
      end else begin
        ref_mem[e_add[7:0]] = e_wdt;
      end
    end
    if (gh || !hr) scnt = 0;
    else if (scnt < LIMIT) scnt = scnt + 1;
    core_hold  = cr && !gc;
    host_clear = gh;
    seen_gnt   = host_gnt;
    seen_stall = core_stall;
  endtask

  task automatic step(input bit c_req, input bit c_wrb, input logic [15:0] c_add, input logic [15:0] c_wdt,
                      input bit h_new, input bit h_wrb, input logic [15:0] h_add, input logic [15:0] h_wdt);
    if (host_clear) host_req = 1'b0;
    host_clear = 1'b0;
    if (!core_hold) begin
      core_req = c_req; core_wrb = c_wrb; core_add = c_add; core_wdt = c_wdt;
    end
    if (!host_req && h_new) begin
      host_req = 1'b1; host_wrb = h_wrb; host_add = h_add; host_wdt = h_wdt;
    end
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0, 16'h0);
  endtask

  // Two reset cycles with both requests up; the host request stays pending across it.
  task automatic do_reset(input bit h_wrb, input logic [15:0] h_add, input logic [15:0] h_wdt);
    reset = 1'b1;
    core_req = 1'b1; core_wrb = 1'b1; core_add = 16'h0003;
    host_req = 1'b1; host_wrb = h_wrb; host_add = h_add; host_wdt = h_wdt;
    host_clear = 1'b0;
    core_hold  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mem_cslt", mem_cslt, 1'b0);
      chk("rst_mem_wrb", mem_wrb, 1'b1);
      chk("rst_mem_add", mem_add, 16'h0);
      chk("rst_mem_wdt", mem_wdt, 16'h0);
      chk("rst_host_gnt", host_gnt, 1'b0);
      chk("rst_core_stall", core_stall, 1'b0);
      chk("rst_host_rvalid", host_rvalid, 1'b0);
      if (i == 1) begin
        chk("rst_core_rdt", core_rdt, 16'h0);
        chk("rst_host_rdt", host_rdt, 16'h0);
        cq.delete();
        hq.delete();
        exp_core = '0;
        exp_host = '0;
        scnt = 0;
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // Monitor: retires expected read returns as the DUT presents them.
  initial begin
    bit e_rv;
    forever begin
      @(negedge clk);
      if (!reset) begin
        while (cq.size() > 0 && cq[0].due <= cyc) begin
          exp_core = cq[0].val;
          void'(cq.pop_front());
        end
        chk("core_rdt", core_rdt, exp_core);
        e_rv = hq.size() > 0 && hq[0].due == cyc;
        chk("host_rvalid", host_rvalid, e_rv);
        if (e_rv) begin
          exp_host = hq[0].val;
          void'(hq.pop_front());
        end
        chk("host_rdt", host_rdt, exp_host);
      end
    end
  end

  initial begin
    int gnt_at, stalls;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    @(posedge clk);
    #1;
    do_reset(1'b0, 16'h0040, 16'h7777);
    // Core wins the first cycle after reset, the pending host write follows.
    step(1'b1, 1'b1, 16'h0005, 16'h0, 1'b0, 1'b1, 16'h0, 16'h0);
    idle(2);
    step(1'b0, 1'b1, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'hBEEF);
    step(1'b1, 1'b1, 16'h0010, 16'h0, 1'b0, 1'b1, 16'h0, 16'h0);
    step(1'b0, 1'b1, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h1234);
    step(1'b0, 1'b1, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h5A5A);
    step(1'b0, 1'b1, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0001, 16'hAAAA);
    step(1'b0, 1'b1, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h5555);
    idle(3);
    chk("beef_core_rdt", core_rdt, 16'hBEEF);

    // Host read under a busy core: forced grant with the guard, idle-cycle grant without.
    gnt_at = 0;
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      step(i < 8, 1'b1, 16'($urandom_range(0, 15)), 16'h0, i == 0, 1'b1, 16'h0030, 16'h0);
      if (seen_gnt && gnt_at == 0) gnt_at = i + 1;
      if (seen_stall) stalls++;
    end
    chk("host_grant_cycle", gnt_at, GUARD ? LIMIT + 1 : 9);
    chk("stall_count", stalls, GUARD ? 1 : 0);
    chk("starve_host_rdt", host_rdt, 16'h5A5A);

    // Back-to-back core read then host read.
    step(1'b1, 1'b1, 16'h0001, 16'h0, 1'b0, 1'b1, 16'h0, 16'h0);
    step(1'b0, 1'b1, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0002, 16'h0);
    idle(3);
    chk("b2b_core_rdt", core_rdt, 16'hAAAA);
    chk("b2b_host_rdt", host_rdt, 16'h5555);

    // Reset straight after a host read grant drops the return.
    step(1'b0, 1'b1, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0020, 16'h0);
    do_reset(1'b1, 16'h0007, 16'h0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 16'($urandom_range(0, 15)),
           16'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           16'($urandom_range(0, 15)), 16'($urandom));
    end
    idle(6);
    chk("core_queue_drained", cq.size(), 0);
    chk("host_queue_drained", hq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
